voq_ingress: RTL and testbench
==============================

Name: voq_ingress

Overview:
Parametrised ingress stage of the packet switch. Accepts packet words per input port over the Avalon-MM slave and steers each packet into the virtual output queue (VOQ) RAM for its (input, output) pair. Tracks per-VOQ write, commit and free space, with packet counts for the scheduler. Adds full-queue drop with pointer rollback, invalid-destination drop, status readback and an async active-low reset.

Parameters:
NUM_PORTS, 4, switch radix; VOQ count = NUM_PORTS*NUM_PORTS
DATA_W, 32, packet word / bus width
DEPTH, 8192, words per VOQ RAM (power of 2); ADDR_W = $clog2(DEPTH)
CNT_W, 16, per-VOQ packet counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
chipselect, write, read  in  1 each  Avalon-MM slave strobes
address  in  5  register/port select
writedata  in  DATA_W  bus write data
readdata  out  DATA_W  registered read data, latency 1
ram_wren  out  NUM_PORTS*NUM_PORTS  per-VOQ write strobe, index i*NUM_PORTS+j
ram_wraddr  out  NUM_PORTS*NUM_PORTS*ADDR_W  per-VOQ write address
ram_wrdata  out  NUM_PORTS*DATA_W  per-input write data, shared by that input's VOQs
rd_ptr  in  NUM_PORTS*NUM_PORTS*(ADDR_W+1)  scheduler consumed pointer per VOQ
pkt_release  in  NUM_PORTS*NUM_PORTS  one-cycle pulse: scheduler finished one packet
commit_ptr  out  NUM_PORTS*NUM_PORTS*(ADDR_W+1)  end of last complete packet per VOQ
pkt_count  out  NUM_PORTS*NUM_PORTS*CNT_W  complete packets waiting per VOQ
tx_start, rx_start  out  1 each  one-cycle control pulses

Behaviour:
- Reset (reset_n low, async): all outputs 0; all pointers/counts 0; every input FSM IDLE; sticky flags 0.
- Bus write to address p < NUM_PORTS feeds input p. Per-input FSM:
  IDLE: zero word ignored. Non-zero word = header; dest = writedata[$clog2(NUM_PORTS)-1:0]. If dest >= NUM_PORTS (non-power-of-2 radix): set bad_dest[p], go DROP. Else write header to VOQ(p,dest), go PKT.
  PKT: every word written to VOQ(p,dest). Zero word (terminator) is written, then commit_ptr <= wr_ptr+1, pkt_count++, go IDLE.
  DROP: words discarded; zero word -> IDLE.
- Full rule: free = DEPTH - (wr_ptr - rd_ptr) on ADDR_W+1 bits. A write with free == 0 is not performed: wr_ptr <= commit_ptr (rollback of partial packet), overflow[p] set, go DROP. A full VOQ at header time drops the whole packet.
- RAM write: ram_wren/ram_wraddr/ram_wrdata registered; asserted exactly one cycle after the accepted bus write; wr_ptr increments the same cycle. ram_wraddr = wr_ptr[ADDR_W-1:0] (wraps modulo DEPTH).
- pkt_release on VOQ k: pkt_count-- (no decrement below 0). Simultaneous commit and release on the same VOQ: count unchanged. pkt_count saturates at 2^CNT_W-1.
- Control writes: 16 = clear: all pointers, counts and FSMs to reset state in one cycle; clear has priority over a same-cycle release. 17 = tx_start pulse. 18 = rx_start pulse. 19 = VOQ select register (writedata index).
- Reads (registered, latency 1): p < NUM_PORTS -> {state[1:0], dest, overflow[p], bad_dest[p]} in low bits; 20 -> overflow vector; 21 -> bad_dest vector; 22 -> pkt_count of selected VOQ; 23 -> occupancy (wr_ptr - rd_ptr) of selected VOQ. Reading 20/21 clears those flags. Unmapped -> 0.
- Writes to unmapped addresses are ignored. Reset mid-packet: partial data abandoned, pointers 0.

Decomposition:
- Package switch_pkg: NUM_PORTS default, DATA_W, register address constants, fsm state enum (IDLE, PKT, DROP), voq_index function.
- Sub-module voq_ctrl (one per VOQ, generate loop): wr_ptr, commit_ptr, free calc, pkt_count, rollback. Top holds per-input FSMs, bus decode, readback.

Test Plan:
- Write 0x5 then 0xAA, 0xBB, 0x0 to address 2 -> VOQ(2,1) writes at addresses 0..3, commit_ptr = 4, pkt_count = 1; all other ram_wren stay 0.
- Write 0x0 to address 0 while IDLE -> no ram_wren, state IDLE.
- DEPTH=8, rd_ptr=0: packet of 10 words to VOQ(0,3) -> 8 writes, then rollback wr_ptr to 0, overflow[0]=1, remaining words dropped, pkt_count 0; next packet after terminator accepted after rd_ptr advances.
- Same-cycle terminator on VOQ(1,0) and pkt_release on it with count=1 -> count stays 1.
- Interleaved packets to address 0 and address 3 targeting same output 2 -> VOQ(0,2) and VOQ(3,2) each hold only their own words.
- reset_n low mid-packet -> all outputs 0 immediately; after release a new header starts at address 0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and constants for the packet switch ingress path.
// Register map, per-input FSM encoding and the VOQ index helper.
package switch_pkg;

    localparam int unsigned DEF_NUM_PORTS = 4;
    localparam int unsigned DEF_DATA_W    = 32;

    localparam logic [4:0] ADDR_CLEAR     = 5'd16;
    localparam logic [4:0] ADDR_TX_START  = 5'd17;
    localparam logic [4:0] ADDR_RX_START  = 5'd18;
    localparam logic [4:0] ADDR_VOQ_SEL   = 5'd19;
    localparam logic [4:0] ADDR_OVERFLOW  = 5'd20;
    localparam logic [4:0] ADDR_BAD_DEST  = 5'd21;
    localparam logic [4:0] ADDR_PKT_COUNT = 5'd22;
    localparam logic [4:0] ADDR_OCCUPANCY = 5'd23;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPkt  = 2'd1,
        StDrop = 2'd2
    } fsm_state_e;

    // VOQ(i,j) lives at flat index i*NUM_PORTS+j.
    function automatic int unsigned voq_index(int unsigned in_port, int unsigned out_port,
                                              int unsigned num_ports);
        return in_port * num_ports + out_port;
    endfunction

endpackage

// File: rtl/voq_ctrl.sv
// Pointer and packet-count bookkeeping for a single virtual output queue.
// A write into a full queue rolls wr_ptr back to the last committed packet end.
module voq_ctrl #(
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              wr_req_i,
    input  logic              wr_last_i,
    input  logic              release_i,
    input  logic [ADDR_W:0]   rd_ptr_i,
    output logic              full_o,
    output logic              ram_wren_o,
    output logic [ADDR_W-1:0] ram_wraddr_o,
    output logic [ADDR_W:0]   commit_ptr_o,
    output logic [ADDR_W:0]   occupancy_o,
    output logic [CNT_W-1:0]  pkt_count_o
);

    localparam logic [ADDR_W:0] DepthVal = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PtrOne   = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   commit_ptr_q, commit_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic [ADDR_W:0]   free;
    logic              do_commit;

    assign occupancy_o  = wr_ptr_q - rd_ptr_i;
    assign free         = DepthVal - occupancy_o;
    assign full_o       = (free == '0);
    assign ram_wren_o   = wren_q;
    assign ram_wraddr_o = wraddr_q;
    assign commit_ptr_o = commit_ptr_q;
    assign pkt_count_o  = count_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wren_d       = 1'b0;
        wraddr_d     = '0;
        do_commit    = 1'b0;
        if (wr_req_i) begin
            if (full_o) begin
                wr_ptr_d = commit_ptr_q;
            end else begin
                wren_d   = 1'b1;
                wraddr_d = wr_ptr_q[ADDR_W-1:0];
                wr_ptr_d = wr_ptr_q + PtrOne;
                if (wr_last_i) begin
                    commit_ptr_d = wr_ptr_q + PtrOne;
                    do_commit    = 1'b1;
                end
            end
        end

        // A commit and a release in the same cycle cancel out.
        count_d = count_q;
        if (do_commit && !release_i) begin
            if (count_q != '1) count_d = count_q + CntOne;
        end else if (!do_commit && release_i && (count_q != '0)) begin
            count_d = count_q - CntOne;
        end

        if (clear_i) begin
            wr_ptr_d     = '0;
            commit_ptr_d = '0;
            count_d      = '0;
            wren_d       = 1'b0;
            wraddr_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
            wren_q       <= 1'b0;
            wraddr_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            count_q      <= count_d;
            wren_q       <= wren_d;
            wraddr_q     <= wraddr_d;
        end
    end

endmodule

// File: rtl/voq_ingress.sv
// Ingress stage: per-input packet FSMs steer bus words into per-(input,output) VOQ RAMs.
// Also provides the control/status register window on the Avalon-MM slave.
module voq_ingress
    import switch_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = 8192,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned ADDR_W   = $clog2(DEPTH),
    localparam int unsigned NUM_VOQ  = NUM_PORTS * NUM_PORTS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic                          read,
    input  logic [4:0]                    address,
    input  logic [DATA_W-1:0]             writedata,
    output logic [DATA_W-1:0]             readdata,
    output logic [NUM_VOQ-1:0]            ram_wren,
    output logic [NUM_VOQ*ADDR_W-1:0]     ram_wraddr,
    output logic [NUM_PORTS*DATA_W-1:0]   ram_wrdata,
    input  logic [NUM_VOQ*(ADDR_W+1)-1:0] rd_ptr,
    input  logic [NUM_VOQ-1:0]            pkt_release,
    output logic [NUM_VOQ*(ADDR_W+1)-1:0] commit_ptr,
    output logic [NUM_VOQ*CNT_W-1:0]      pkt_count,
    output logic                          tx_start,
    output logic                          rx_start
);

    localparam int unsigned DEST_W = $clog2(NUM_PORTS);
    localparam int unsigned SEL_W  = $clog2(NUM_VOQ);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    fsm_state_e          state_q  [NUM_PORTS];
    fsm_state_e          state_d  [NUM_PORTS];
    logic [DEST_W-1:0]   dest_q   [NUM_PORTS];
    logic [DEST_W-1:0]   dest_d   [NUM_PORTS];
    logic [DATA_W-1:0]   wrdata_q [NUM_PORTS];
    logic [DATA_W-1:0]   wrdata_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] overflow_q, overflow_d;
    logic [NUM_PORTS-1:0] bad_dest_q, bad_dest_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   readdata_q, readdata_d;
    logic                tx_q, rx_q;

    logic [NUM_VOQ-1:0]  voq_wr, voq_last, voq_full;
    logic [PTR_W-1:0]    occupancy [NUM_VOQ];

    logic                bus_wr, bus_rd, clear, word_zero;
    logic [DEST_W-1:0]   hdr_dest;

    assign bus_wr    = chipselect & write;
    assign bus_rd    = chipselect & read;
    assign clear     = bus_wr && (address == ADDR_CLEAR);
    assign word_zero = (writedata == '0);
    assign hdr_dest  = writedata[DEST_W-1:0];

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        wrdata_d   = wrdata_q;
        overflow_d = overflow_q;
        bad_dest_d = bad_dest_q;
        voq_wr     = '0;
        voq_last   = '0;

        if (bus_rd && (address == ADDR_OVERFLOW)) overflow_d = '0;
        if (bus_rd && (address == ADDR_BAD_DEST)) bad_dest_d = '0;

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus_wr && (32'(address) == p)) begin
                wrdata_d[p] = writedata;
                case (state_q[p])
                    StIdle: begin
                        if (!word_zero) begin
                            if (32'(hdr_dest) >= NUM_PORTS) begin
                                bad_dest_d[p] = 1'b1;
                                state_d[p]    = StDrop;
                            end else begin
                                dest_d[p]  = hdr_dest;
                                state_d[p] = StPkt;
                                for (int j = 0; j < NUM_PORTS; j++) begin
                                    if (32'(hdr_dest) == j) begin
                                        voq_wr[voq_index(p, j, NUM_PORTS)] = 1'b1;
                                        if (voq_full[voq_index(p, j, NUM_PORTS)]) begin
                                            overflow_d[p] = 1'b1;
                                            state_d[p]    = StDrop;
                                        end
                                    end
                                end
                            end
                        end
                    end
                    StPkt: begin
                        for (int j = 0; j < NUM_PORTS; j++) begin
                            if (32'(dest_q[p]) == j) begin
                                voq_wr[voq_index(p, j, NUM_PORTS)]   = 1'b1;
                                voq_last[voq_index(p, j, NUM_PORTS)] = word_zero;
                                if (voq_full[voq_index(p, j, NUM_PORTS)]) begin
                                    overflow_d[p] = 1'b1;
                                    state_d[p]    = StDrop;
                                end else if (word_zero) begin
                                    state_d[p] = StIdle;
                                end
                            end
                        end
                    end
                    StDrop: begin
                        if (word_zero) state_d[p] = StIdle;
                    end
                    default: state_d[p] = StIdle;
                endcase
            end
        end

        if (clear) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_d[p] = StIdle;
                dest_d[p]  = '0;
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (bus_wr && (address == ADDR_VOQ_SEL)) sel_d = writedata[SEL_W-1:0];
    end

    always_comb begin
        readdata_d = '0;
        if (bus_rd) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (32'(address) == p) begin
                    readdata_d[DEST_W+3:0] = {state_q[p], dest_q[p], overflow_q[p], bad_dest_q[p]};
                end
            end
            case (address)
                ADDR_OVERFLOW: readdata_d[NUM_PORTS-1:0] = overflow_q;
                ADDR_BAD_DEST: readdata_d[NUM_PORTS-1:0] = bad_dest_q;
                ADDR_PKT_COUNT: begin
                    for (int k = 0; k < NUM_VOQ; k++) begin
                        if (32'(sel_q) == k) readdata_d[CNT_W-1:0] = pkt_count[k*CNT_W +: CNT_W];
                    end
                end
                ADDR_OCCUPANCY: begin
                    for (int k = 0; k < NUM_VOQ; k++) begin
                        if (32'(sel_q) == k) readdata_d[PTR_W-1:0] = occupancy[k];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p]  <= StIdle;
                dest_q[p]   <= '0;
                wrdata_q[p] <= '0;
            end
            overflow_q <= '0;
            bad_dest_q <= '0;
            sel_q      <= '0;
            readdata_q <= '0;
            tx_q       <= 1'b0;
            rx_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            wrdata_q   <= wrdata_d;
            overflow_q <= overflow_d;
            bad_dest_q <= bad_dest_d;
            sel_q      <= sel_d;
            readdata_q <= readdata_d;
            tx_q       <= bus_wr && (address == ADDR_TX_START);
            rx_q       <= bus_wr && (address == ADDR_RX_START);
        end
    end

    assign readdata = readdata_q;
    assign tx_start = tx_q;
    assign rx_start = rx_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_wrdata
        assign ram_wrdata[p*DATA_W +: DATA_W] = wrdata_q[p];
    end

    for (genvar k = 0; k < NUM_VOQ; k++) begin : g_voq
        voq_ctrl #(
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W),
            .ADDR_W (ADDR_W)
        ) u_voq_ctrl (
            .clk          (clk),
            .reset_n      (reset_n),
            .clear_i      (clear),
            .wr_req_i     (voq_wr[k]),
            .wr_last_i    (voq_last[k]),
            .release_i    (pkt_release[k]),
            .rd_ptr_i     (rd_ptr[k*PTR_W +: PTR_W]),
            .full_o       (voq_full[k]),
            .ram_wren_o   (ram_wren[k]),
            .ram_wraddr_o (ram_wraddr[k*ADDR_W +: ADDR_W]),
            .commit_ptr_o (commit_ptr[k*PTR_W +: PTR_W]),
            .occupancy_o  (occupancy[k]),
            .pkt_count_o  (pkt_count[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_voq_ingress.sv
// Directed bench for voq_ingress with a small DEPTH so full/rollback and wrap are reachable.
// Expected RAM writes are queued as words are driven and matched against ram_wren.
module tb_voq_ingress;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int CW = 16;
    localparam int AW = 3;
    localparam int PW = AW + 1;
    localparam int NV = NP * NP;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              chipselect = 1'b0;
    logic              write = 1'b0;
    logic              read = 1'b0;
    logic [4:0]        address = '0;
    logic [DW-1:0]     writedata = '0;
    logic [DW-1:0]     readdata;
    logic [NV-1:0]     ram_wren;
    logic [NV*AW-1:0]  ram_wraddr;
    logic [NP*DW-1:0]  ram_wrdata;
    logic [NV*PW-1:0]  rd_ptr = '0;
    logic [NV-1:0]     pkt_release = '0;
    logic [NV*PW-1:0]  commit_ptr;
    logic [NV*CW-1:0]  pkt_count;
    logic              tx_start, rx_start;

    voq_ingress #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .ram_wren    (ram_wren),
        .ram_wraddr  (ram_wraddr),
        .ram_wrdata  (ram_wrdata),
        .rd_ptr      (rd_ptr),
        .pkt_release (pkt_release),
        .commit_ptr  (commit_ptr),
        .pkt_count   (pkt_count),
        .tx_start    (tx_start),
        .rx_start    (rx_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          voq;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] cptr(input int k);
        return commit_ptr[k*PW +: PW];
    endfunction

    function automatic logic [CW-1:0] pcnt(input int k);
        return pkt_count[k*CW +: CW];
    endfunction

    // Scoreboard side: every visible RAM write must match the oldest expected one.
    always @(negedge clk) begin
        int  v;
        wr_t e;
        v = -1;
        if (reset_n && (ram_wren != '0)) begin
            for (int k = 0; k < NV; k++) if (ram_wren[k]) v = k;
            check("wren_onehot", 64'($countones(ram_wren)), 64'(1));
            if (exp_q.size() == 0) begin
                check("unexpected_write_voq", 64'(v), 64'(99));
            end else begin
                e = exp_q.pop_front();
                check("wr_voq", 64'(v), 64'(e.voq));
                check("wr_addr", 64'(ram_wraddr[v*AW +: AW]), 64'(e.addr));
                check("wr_data", 64'(ram_wrdata[(v/NP)*DW +: DW]), 64'(e.data));
            end
        end
    end

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
        address    = '0;
    endtask

    task automatic wr_exp(input logic [4:0] port, input int voq, input int addr,
                          input logic [31:0] d);
        wr_t e;
        e.voq  = voq;
        e.addr = addr;
        e.data = d;
        exp_q.push_back(e);
        bus_write(port, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;

        repeat (2) @(negedge clk);
        check("reset_wren", 64'(ram_wren), 64'(0));
        check("reset_commit", commit_ptr, 64'(0));
        check("reset_count_any", 64'(|pkt_count), 64'(0));
        check("reset_readdata", 64'(readdata), 64'(0));
        check("reset_tx_rx", 64'({tx_start, rx_start}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Basic packet on input 2 to output 1.
        wr_exp(5'd2, 9, 0, 32'h5);
        wr_exp(5'd2, 9, 1, 32'hAA);
        wr_exp(5'd2, 9, 2, 32'hBB);
        wr_exp(5'd2, 9, 3, 32'h0);
        check("basic_commit", 64'(cptr(9)), 64'(4));
        check("basic_count", 64'(pcnt(9)), 64'(1));
        bus_read(5'd2, rd);
        check("basic_status", 64'(rd), 64'(32'h4));

        // Zero word while idle is ignored.
        bus_write(5'd0, 32'h0);
        bus_read(5'd0, rd);
        check("idle_zero_status", 64'(rd), 64'(0));

        // 10-word packet into an 8-deep VOQ(0,3): 8 writes, rollback, drop.
        wr_exp(5'd0, 3, 0, 32'h3);
        for (int i = 1; i < 8; i++) wr_exp(5'd0, 3, i, 32'h10 + 32'(i));
        bus_write(5'd0, 32'h18);
        bus_write(5'd0, 32'h0);
        check("ovf_commit", 64'(cptr(3)), 64'(0));
        check("ovf_count", 64'(pcnt(3)), 64'(0));
        bus_write(5'd19, 32'd3);
        bus_read(5'd23, rd);
        check("ovf_occupancy", 64'(rd), 64'(0));
        bus_read(5'd0, rd);
        check("ovf_status", 64'(rd), 64'(32'hE));
        bus_read(5'd20, rd);
        check("ovf_vector", 64'(rd), 64'(1));
        bus_read(5'd20, rd);
        check("ovf_vector_cleared", 64'(rd), 64'(0));

        wr_exp(5'd0, 3, 0, 32'h3);
        for (int i = 1; i < 5; i++) wr_exp(5'd0, 3, i, 32'h20 + 32'(i));
        wr_exp(5'd0, 3, 5, 32'h0);
        check("after_ovf_commit", 64'(cptr(3)), 64'(6));
        check("after_ovf_count", 64'(pcnt(3)), 64'(1));
        rd_ptr[3*PW +: PW] = 4'd6;
        pkt_release[3] = 1'b1;
        @(negedge clk);
        pkt_release[3] = 1'b0;
        check("release_count", 64'(pcnt(3)), 64'(0));
        // Wraps the RAM address past DEPTH.
        wr_exp(5'd0, 3, 6, 32'h3);
        wr_exp(5'd0, 3, 7, 32'h31);
        wr_exp(5'd0, 3, 0, 32'h32);
        wr_exp(5'd0, 3, 1, 32'h33);
        wr_exp(5'd0, 3, 2, 32'h0);
        check("wrap_commit", 64'(cptr(3)), 64'(11));
        bus_read(5'd23, rd);
        check("wrap_occupancy", 64'(rd), 64'(5));

        // Release at zero does not underflow; commit+release together holds count.
        pkt_release[4] = 1'b1;
        @(negedge clk);
        pkt_release[4] = 1'b0;
        check("release_at_zero", 64'(pcnt(4)), 64'(0));
        wr_exp(5'd1, 4, 0, 32'h4);
        wr_exp(5'd1, 4, 1, 32'h0);
        check("voq4_count1", 64'(pcnt(4)), 64'(1));
        wr_exp(5'd1, 4, 2, 32'h4);
        wr_exp(5'd1, 4, 3, 32'h41);
        pkt_release[4] = 1'b1;
        wr_exp(5'd1, 4, 4, 32'h0);
        pkt_release[4] = 1'b0;
        check("same_cycle_count", 64'(pcnt(4)), 64'(1));
        check("same_cycle_commit", 64'(cptr(4)), 64'(5));

        // Interleaved packets from inputs 0 and 3 to output 2.
        wr_exp(5'd0, 2, 0, 32'h2);
        wr_exp(5'd3, 14, 0, 32'h6);
        wr_exp(5'd0, 2, 1, 32'hA1);
        wr_exp(5'd3, 14, 1, 32'hB1);
        wr_exp(5'd0, 2, 2, 32'h0);
        wr_exp(5'd3, 14, 2, 32'h0);
        check("ilv_commit_0", 64'(cptr(2)), 64'(3));
        check("ilv_commit_3", 64'(cptr(14)), 64'(3));
        check("ilv_count", 64'({pcnt(2), pcnt(14)}), 64'({16'd1, 16'd1}));

        bus_write(5'd17, 32'h0);
        check("tx_pulse", 64'({tx_start, rx_start}), 64'(2'b10));
        @(negedge clk);
        check("tx_pulse_end", 64'(tx_start), 64'(0));
        bus_write(5'd18, 32'h0);
        check("rx_pulse", 64'({tx_start, rx_start}), 64'(2'b01));

        // Clear with a partial packet in flight and a same-cycle release.
        wr_exp(5'd1, 5, 0, 32'h5);
        wr_exp(5'd1, 5, 1, 32'h55);
        pkt_release[2] = 1'b1;
        bus_write(5'd16, 32'h0);
        pkt_release[2] = 1'b0;
        rd_ptr = '0;
        check("clear_commit", commit_ptr, 64'(0));
        check("clear_count_any", 64'(|pkt_count), 64'(0));
        bus_read(5'd1, rd);
        check("clear_status", 64'(rd), 64'(0));
        bus_write(5'd19, 32'd5);
        bus_read(5'd23, rd);
        check("clear_occupancy", 64'(rd), 64'(0));
        wr_exp(5'd1, 5, 0, 32'h5);
        wr_exp(5'd1, 5, 1, 32'h0);
        check("post_clear_commit", 64'(cptr(5)), 64'(2));

        // Asynchronous reset mid-packet.
        wr_exp(5'd0, 1, 0, 32'h1);
        wr_exp(5'd0, 1, 1, 32'h77);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_wren", 64'(ram_wren), 64'(0));
        check("async_commit", commit_ptr, 64'(0));
        check("async_count_any", 64'(|pkt_count), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wr_exp(5'd0, 1, 0, 32'h1);
        wr_exp(5'd0, 1, 1, 32'h0);
        check("post_reset_commit", 64'(cptr(1)), 64'(2));
        check("post_reset_count", 64'(pcnt(1)), 64'(1));

        repeat (3) @(negedge clk);
        check("exp_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
